// File: rtl/pwm_pkg.sv
// Shared helpers for the multi-channel PWM block: address sizing and register map.
package pwm_pkg;

  localparam int DEF_CHANNELS = 4;

  function automatic int addr_width(input int channels);
    return $clog2(channels + 1);
  endfunction

  // Duty registers occupy 0..channels-1; the period register sits just above them.
  function automatic int period_addr(input int channels);
    return channels;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty, compare against the shared counter, registered output.
module pwm_channel #(
  parameter int COUNTER_BITS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [COUNTER_BITS-1:0] cnt,
  input  logic                    commit,
  input  logic                    wr,
  input  logic [COUNTER_BITS-1:0] wr_data,
  input  logic                    invert,
  output logic                    pwm_out
);

  logic [COUNTER_BITS-1:0] duty_sh;
  logic [COUNTER_BITS-1:0] duty_act;

  // The active duty loads the pre-write shadow, so a write landing on a wrap waits a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm_out  <= invert;
    end else begin
      if (wr)
        duty_sh <= wr_data;
      if (commit)
        duty_act <= duty_sh;
      if (!enable)
        pwm_out <= invert;
      else
        pwm_out <= (cnt < duty_act) ^ invert;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// N-channel PWM sharing one programmable-period counter with glitch-free shadow commits at wrap.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int                      CHANNELS     = DEF_CHANNELS,
  parameter int                      COUNTER_BITS = 16,
  parameter logic [COUNTER_BITS-1:0] RESET_PERIOD = '1,
  parameter logic [CHANNELS-1:0]     INVERT       = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              wr_en,
  input  logic [addr_width(CHANNELS)-1:0]   wr_addr,
  input  logic [COUNTER_BITS-1:0]           wr_data,
  output logic [CHANNELS-1:0]               pwm_out,
  output logic                              period_strb,
  output logic                              upd_pending
);

  localparam int AW    = addr_width(CHANNELS);
  localparam int PADDR = period_addr(CHANNELS);

  logic [COUNTER_BITS-1:0] cnt;
  logic [COUNTER_BITS-1:0] period_sh;
  logic [COUNTER_BITS-1:0] period_act;
  logic                    wrap;
  logic                    commit;
  logic                    period_wr;
  logic                    any_wr;
  logic [CHANNELS-1:0]     duty_wr;

  assign wrap   = enable && (cnt == period_act);
  // While idle the active copies simply follow the shadows.
  assign commit = !enable || wrap;

  always_comb begin
    duty_wr = '0;
    for (int i = 0; i < CHANNELS; i++)
      duty_wr[i] = wr_en && (wr_addr == AW'(i));
  end

  assign period_wr = wr_en && (wr_addr == AW'(PADDR));
  assign any_wr    = period_wr || (|duty_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      period_sh   <= RESET_PERIOD;
      period_act  <= RESET_PERIOD;
      period_strb <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      if (!enable || wrap)
        cnt <= '0;
      else
        cnt <= cnt + COUNTER_BITS'(1);

      if (period_wr)
        period_sh <= wr_data;
      if (commit)
        period_act <= period_sh;

      period_strb <= enable && (cnt == '0);

      // A write on the wrap cycle outranks the clear: its value is still uncommitted.
      if (!enable)
        upd_pending <= 1'b0;
      else if (any_wr)
        upd_pending <= 1'b1;
      else if (wrap)
        upd_pending <= 1'b0;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .COUNTER_BITS(COUNTER_BITS)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .cnt     (cnt),
      .commit  (commit),
      .wr      (duty_wr[g]),
      .wr_data (wr_data),
      .invert  (INVERT[g]),
      .pwm_out (pwm_out[g])
    );
  end

endmodule
